// File: rtl/tlb_engine.sv
// MIPS-style TLB maintenance engine: TLBWI/TLBR complete in one cycle,
// TLBP walks entries one per cycle from index 0 and reports the first hit.
module tlb_engine #(
    parameter int unsigned TLBNUM = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    output logic        op_ready,
    input  logic        flush,
    input  logic [31:0] cp0_index,
    input  logic [31:0] cp0_entryhi,
    input  logic [31:0] cp0_pagemask,
    input  logic [31:0] cp0_entrylo0,
    input  logic [31:0] cp0_entrylo1,
    output logic        res_valid,
    output logic [1:0]  res_type,
    output logic [31:0] Index_out,
    output logic [31:0] EntryHi_out,
    output logic [31:0] PageMask_out,
    output logic [31:0] EntryLo0_out,
    output logic [31:0] EntryLo1_out
);

    localparam int unsigned IDX_W = 4;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBP  = 2'b10;
    localparam logic [1:0] OP_TLBWI = 2'b11;

    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [11:0] mask;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    tlb_entry_t           entries [TLBNUM];
    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [18:0]          probe_vpn2;
    logic [7:0]           probe_asid;

    logic                 accept_c;
    logic [IDX_W-1:0]     op_idx_c;
    tlb_entry_t           wr_entry_c;
    tlb_entry_t           rd_entry_c;
    logic                 hit_c;
    logic                 last_c;
    logic                 unused_c;

    assign op_idx_c = cp0_index[IDX_W-1:0];
    assign accept_c = op_valid & op_ready & ~flush & (op_type != 2'b00);
    assign rd_entry_c = entries[op_idx_c];
    assign last_c = (ptr == IDX_W'(TLBNUM - 1));

    assign unused_c = ^{cp0_index[31:IDX_W], cp0_entryhi[12:8], cp0_pagemask[31:25],
                        cp0_pagemask[12:0], cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

    // Entry image built from the CP0 operands for TLBWI
    always_comb begin
        wr_entry_c      = '0;
        wr_entry_c.vpn2 = cp0_entryhi[31:13];
        wr_entry_c.asid = cp0_entryhi[7:0];
        wr_entry_c.mask = cp0_pagemask[24:13];
        wr_entry_c.g    = cp0_entrylo0[0] & cp0_entrylo1[0];
        wr_entry_c.pfn0 = cp0_entrylo0[25:6];
        wr_entry_c.c0   = cp0_entrylo0[5:3];
        wr_entry_c.d0   = cp0_entrylo0[2];
        wr_entry_c.v0   = cp0_entrylo0[1];
        wr_entry_c.pfn1 = cp0_entrylo1[25:6];
        wr_entry_c.c1   = cp0_entrylo1[5:3];
        wr_entry_c.d1   = cp0_entrylo1[2];
        wr_entry_c.v1   = cp0_entrylo1[1];
    end

    // Masked VPN2 compare on the low 12 bits, exact on the top 7; valid bits ignored
    always_comb begin
        hit_c = (entries[ptr].vpn2[18:12] == probe_vpn2[18:12])
             && ((entries[ptr].vpn2[11:0] & ~entries[ptr].mask)
                 == (probe_vpn2[11:0] & ~entries[ptr].mask))
             && (entries[ptr].g || (entries[ptr].asid == probe_asid));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(TLBNUM); i++) begin
                entries[i] <= '0;
            end
        end else if (accept_c && (op_type == OP_TLBWI)) begin
            entries[op_idx_c] <= wr_entry_c;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            ptr          <= '0;
            probe_vpn2   <= '0;
            probe_asid   <= '0;
            op_ready     <= 1'b1;
            res_valid    <= 1'b0;
            res_type     <= 2'b00;
            Index_out    <= '0;
            EntryHi_out  <= '0;
            PageMask_out <= '0;
            EntryLo0_out <= '0;
            EntryLo1_out <= '0;
        end else begin
            res_valid <= 1'b0;
            res_type  <= 2'b00;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        op_ready <= 1'b0;
                        case (op_type)
                            OP_TLBR: begin
                                EntryHi_out  <= {rd_entry_c.vpn2, 5'b0, rd_entry_c.asid};
                                PageMask_out <= {7'b0, rd_entry_c.mask, 13'b0};
                                EntryLo0_out <= {6'b0, rd_entry_c.pfn0, rd_entry_c.c0,
                                                 rd_entry_c.d0, rd_entry_c.v0, rd_entry_c.g};
                                EntryLo1_out <= {6'b0, rd_entry_c.pfn1, rd_entry_c.c1,
                                                 rd_entry_c.d1, rd_entry_c.v1, rd_entry_c.g};
                                state     <= DONE;
                                res_valid <= 1'b1;
                                res_type  <= 2'b01;
                            end
                            OP_TLBP: begin
                                ptr        <= '0;
                                probe_vpn2 <= cp0_entryhi[31:13];
                                probe_asid <= cp0_entryhi[7:0];
                                state      <= PROBE;
                            end
                            default: begin
                                state     <= DONE;
                                res_valid <= 1'b1;
                                res_type  <= 2'b00;
                            end
                        endcase
                    end
                end
                PROBE: begin
                    if (flush) begin
                        state    <= IDLE;
                        op_ready <= 1'b1;
                    end else if (hit_c || last_c) begin
                        Index_out <= hit_c ? 32'(ptr) : 32'h8000_0000;
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_type  <= 2'b10;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
